// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: EX/MEM destination shadow,
// registered forwarding selects, load-use / mul-div / branch-flush sequencing, stall counter.
module hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16,
  parameter bit MD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_muldiv,
  input  logic              ex_branch_taken,
  input  logic              md_done,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic [1:0]        fwd_sel_rs1,
  output logic [1:0]        fwd_sel_rs2,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MD_BUSY  = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ADDR_W-1:0]  ex_rd_r;
  logic               ex_wen_r;
  logic               ex_ld_r;
  logic               ex_md_r;
  logic [ADDR_W-1:0]  mem_rd_r;
  logic               mem_wen_r;
  logic [1:0]         fwd_sel_rs1_r;
  logic [1:0]         fwd_sel_rs2_r;
  logic [CNT_W-1:0]   stall_count_r;

  logic               stall_s;
  logic               bubble_s;
  logic               flush_s;
  logic               frozen_s;
  logic               load_use_s;
  logic               md_wait_s;
  logic               advance_s;
  logic               kill_id_s;

  function automatic logic src_match(input logic [ADDR_W-1:0] src, input logic used,
                                     input logic wen, input logic [ADDR_W-1:0] rd);
    return (src != {ADDR_W{1'b0}}) && used && wen && (src == rd);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [ADDR_W-1:0] src, input logic used,
                                          input logic [ADDR_W-1:0] e_rd, input logic e_wen,
                                          input logic [ADDR_W-1:0] m_rd, input logic m_wen);
    logic [1:0] sel;
    if (src_match(src, used, e_wen, e_rd)) begin
      sel = 2'b01;
    end else if (src_match(src, used, m_wen, m_rd)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign load_use_s = id_valid && ex_ld_r &&
                      (src_match(id_rs1, id_rs1_used, ex_wen_r, ex_rd_r) ||
                       src_match(id_rs2, id_rs2_used, ex_wen_r, ex_rd_r));
  assign md_wait_s  = MD_EN && ex_md_r && !md_done;
  assign advance_s  = !stall_s && !bubble_s;
  assign kill_id_s  = bubble_s || !id_valid;

  // Hazard priority (flush > mul/div > load-use) and next-state selection
  always_comb begin
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    flush_s     = 1'b0;
    frozen_s    = 1'b0;
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN, ST_LD_STALL: begin
        if (ex_branch_taken) begin
          flush_s     = 1'b1;
          bubble_s    = 1'b1;
          state_nxt_s = ST_FLUSH;
        end else if (md_wait_s) begin
          stall_s     = 1'b1;
          frozen_s    = 1'b1;
          state_nxt_s = ST_MD_BUSY;
        end else if (load_use_s) begin
          stall_s     = 1'b1;
          bubble_s    = 1'b1;
          state_nxt_s = ST_LD_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MD_BUSY: begin
        if (md_done || !MD_EN) begin
          state_nxt_s = ST_RUN;
        end else begin
          stall_s     = 1'b1;
          frozen_s    = 1'b1;
          state_nxt_s = ST_MD_BUSY;
        end
      end
      ST_FLUSH: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // EX/MEM destination shadow; a frozen EX pushes a bubble into MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_r   <= {ADDR_W{1'b0}};
      ex_wen_r  <= 1'b0;
      ex_ld_r   <= 1'b0;
      ex_md_r   <= 1'b0;
      mem_rd_r  <= {ADDR_W{1'b0}};
      mem_wen_r <= 1'b0;
    end else if (frozen_s) begin
      mem_wen_r <= 1'b0;
    end else begin
      mem_rd_r  <= ex_rd_r;
      mem_wen_r <= ex_wen_r;
      ex_rd_r   <= kill_id_s ? {ADDR_W{1'b0}} : id_rd;
      ex_wen_r  <= id_reg_write && !kill_id_s;
      ex_ld_r   <= id_is_load   && !kill_id_s;
      ex_md_r   <= id_is_muldiv && !kill_id_s;
    end
  end

  // Forward selects follow the ID instruction into EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel_rs1_r <= 2'b00;
      fwd_sel_rs2_r <= 2'b00;
    end else if (advance_s) begin
      fwd_sel_rs1_r <= fwd_pick(id_rs1, id_rs1_used, ex_rd_r, ex_wen_r, mem_rd_r, mem_wen_r);
      fwd_sel_rs2_r <= fwd_pick(id_rs2, id_rs2_used, ex_rd_r, ex_wen_r, mem_rd_r, mem_wen_r);
    end else begin
      fwd_sel_rs1_r <= fwd_sel_rs1_r;
      fwd_sel_rs2_r <= fwd_sel_rs2_r;
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_if    = stall_s;
  assign stall_id    = stall_s;
  assign bubble_ex   = bubble_s;
  assign flush_id    = flush_s;
  assign fwd_sel_rs1 = fwd_sel_rs1_r;
  assign fwd_sel_rs2 = fwd_sel_rs2_r;
  assign hz_state    = state_r;
  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios plus random
// instruction streams checked against a pipeline-level reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0, id_is_muldiv = 1'b0;
  logic       ex_branch_taken = 1'b0, md_done = 1'b0;
  logic       stall_if, stall_id, bubble_ex, flush_id;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2, hz_state;
  logic [15:0] stall_count;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_is_muldiv(id_is_muldiv), .ex_branch_taken(ex_branch_taken), .md_done(md_done),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .hz_state(hz_state),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct { int rd; bit wen; bit ld; bit md; } slot_t;
  typedef struct { bit stall; bit bub; bit fl; int f1; int f2; int st; int cnt; } exp_t;

  exp_t  exp_q[$];
  slot_t m_ex, m_mem;
  int    m_st, m_f1, m_f2, m_cnt;
  int    n_checks = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  function automatic bit hit(input int src, input bit used, input slot_t s);
    return (src != 0) && used && s.wen && (src == s.rd);
  endfunction

  function automatic int pick(input int src, input bit used);
    if (hit(src, used, m_ex)) return 1;
    if (hit(src, used, m_mem)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex = '{0, 1'b0, 1'b0, 1'b0};
    m_mem = '{0, 1'b0, 1'b0, 1'b0};
    m_st = 0; m_f1 = 0; m_f2 = 0; m_cnt = 0;
  endtask

  // One clock of stimulus: drive, predict, queue the prediction, advance the model
  task automatic cyc(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wen, input bit ld, input bit md,
                     input bit br, input bit done);
    exp_t e;
    bit   frz, lu;
    int   nst;
    id_valid = v; id_rs1 = rs1[4:0]; id_rs1_used = u1; id_rs2 = rs2[4:0]; id_rs2_used = u2;
    id_rd = rd[4:0]; id_reg_write = wen; id_is_load = ld; id_is_muldiv = md;
    ex_branch_taken = br; md_done = done;
    e = '{1'b0, 1'b0, 1'b0, m_f1, m_f2, m_st, m_cnt};
    frz = 1'b0;
    lu  = v && m_ex.ld && (hit(rs1, u1, m_ex) || hit(rs2, u2, m_ex));
    if (m_st == 3) begin
      nst = 0;
    end else if (m_st == 2) begin
      if (done) nst = 0;
      else begin e.stall = 1'b1; frz = 1'b1; nst = 2; end
    end else if (br) begin
      e.fl = 1'b1; e.bub = 1'b1; nst = 3;
    end else if (m_ex.md && !done) begin
      e.stall = 1'b1; frz = 1'b1; nst = 2;
    end else if (lu) begin
      e.stall = 1'b1; e.bub = 1'b1; nst = 1;
    end else begin
      nst = 0;
    end
    exp_q.push_back(e);
    if (e.stall && m_cnt < 65535) m_cnt++;
    if (!e.stall && !e.bub) begin
      m_f1 = pick(rs1, u1);
      m_f2 = pick(rs2, u2);
    end
    if (frz) begin
      m_mem.wen = 1'b0;
    end else begin
      m_mem = m_ex;
      if (e.bub || !v) m_ex = '{0, 1'b0, 1'b0, 1'b0};
      else m_ex = '{rd, wen, ld, md};
    end
    m_st = nst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit done);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, done);
  endtask

  task automatic zero_inputs();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = 5'd0; id_reg_write = 1'b0; id_is_load = 1'b0; id_is_muldiv = 1'b0;
    ex_branch_taken = 1'b0; md_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall_if"}, int'(stall_if), 0);
    chk({tag, "_stall_id"}, int'(stall_id), 0);
    chk({tag, "_bubble"}, int'(bubble_ex), 0);
    chk({tag, "_flush"}, int'(flush_id), 0);
    chk({tag, "_fwd1"}, int'(fwd_sel_rs1), 0);
    chk({tag, "_fwd2"}, int'(fwd_sel_rs2), 0);
    chk({tag, "_state"}, int'(hz_state), 0);
    chk({tag, "_count"}, int'(stall_count), 0);
  endtask

  // Called at posedge+1 with an empty scoreboard
  task automatic do_reset(input string tag);
    zero_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pop the prediction for this cycle and compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall_if", int'(stall_if), int'(e.stall));
      chk("stall_id", int'(stall_id), int'(e.stall));
      chk("bubble_ex", int'(bubble_ex), int'(e.bub));
      chk("flush_id", int'(flush_id), int'(e.fl));
      chk("fwd_sel_rs1", int'(fwd_sel_rs1), e.f1);
      chk("fwd_sel_rs2", int'(fwd_sel_rs2), e.f2);
      chk("hz_state", int'(hz_state), e.st);
      chk("stall_count", int'(stall_count), e.cnt);
    end
  end

  initial begin
    bit br, dn, ld, md;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add x5 ; add x6,x5,x7
    cyc(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b1, 7, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_fwd1", int'(fwd_sel_rs1), 1);
    chk("alu_fwd2", int'(fwd_sel_rs2), 0);
    chk("alu_count", int'(stall_count), 0);

    // lw x5 ; add x6,x5,x5
    do_reset("r1");
    cyc(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_state", int'(hz_state), 1);
    chk("ld_count", int'(stall_count), 1);
    cyc(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_fwd1", int'(fwd_sel_rs1), 2);
    chk("ld_fwd2", int'(fwd_sel_rs2), 2);
    chk("ld_state_after", int'(hz_state), 0);
    chk("ld_count_after", int'(stall_count), 1);

    // add x5 ; nop ; sub x8,x5,x0 ; then x0 writer and reader
    do_reset("r2");
    cyc(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b1, 5, 1'b1, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wb_fwd1", int'(fwd_sel_rs1), 2);
    chk("wb_fwd2", int'(fwd_sel_rs2), 0);
    cyc(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b1, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x0_fwd1", int'(fwd_sel_rs1), 0);
    chk("x0_fwd2", int'(fwd_sel_rs2), 0);
    chk("x0_count", int'(stall_count), 0);

    // add x3 ; mul x5,x3,x0 ; add x6,x5,x1 waits four cycles for md_done
    do_reset("r3");
    cyc(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3, 1'b1, 0, 1'b1, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("md_mul_fwd1", int'(fwd_sel_rs1), 1);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("md_state", int'(hz_state), 2);
    chk("md_count", int'(stall_count), 4);
    chk("md_hold_fwd1", int'(fwd_sel_rs1), 1);
    chk("md_hold_fwd2", int'(fwd_sel_rs2), 0);
    cyc(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("md_release_state", int'(hz_state), 0);
    chk("md_release_count", int'(stall_count), 4);

    // branch taken while a load-use sits in ID
    do_reset("r4");
    cyc(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b1, 5, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("br_state", int'(hz_state), 3);
    chk("br_count", int'(stall_count), 0);
    idle(1'b0);
    chk("br_state_after", int'(hz_state), 0);

    // asynchronous reset in the middle of a mul/div wait
    do_reset("r5");
    cyc(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("arst_pre_state", int'(hz_state), 2);
    chk("arst_pre_count", int'(stall_count), 2);
    do_reset("arst");

    // random instruction stream over a small register window
    for (int n = 0; n < 3000; n++) begin
      br = ($urandom_range(0, 9) == 0);
      dn = ($urandom_range(0, 2) == 0);
      ld = ($urandom_range(0, 3) == 0);
      md = !ld && ($urandom_range(0, 6) == 0);
      cyc($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
          $urandom_range(0, 4) != 0, ld, md, br, dn);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Keeps its own shadow copy of the destination registers held in the EX and MEM stages.
- Produces registered forwarding selects for the operand muxes in the EX stage.
- Sequences load-use stalls, multi-cycle mul/div occupancy of EX, and branch flushes through a small FSM, and counts stall cycles for performance monitoring.

Parameters:
- ADDR_W, 5: register address width.
- CNT_W, 16: width of the stall cycle counter (saturating).
- MD_EN, 1: 1 = honour id_is_muldiv and md_done; 0 = treat every instruction as single-cycle.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  a real instruction occupies ID.
- id_rs1 / id_rs2  in  ADDR_W  source register addresses of the ID instruction.
- id_rs1_used / id_rs2_used  in  1  the source is actually read (0 for lui, jal, etc.).
- id_rd  in  ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes rd.
- id_is_load  in  1  the ID instruction is a load.
- id_is_muldiv  in  1  the ID instruction is a multi-cycle mul/div.
- ex_branch_taken  in  1  the EX-stage branch/jump resolved as taken this cycle.
- md_done  in  1  the mul/div unit finishes this cycle.
- stall_if  out  1  hold the PC and IF/ID register.
- stall_id  out  1  hold the ID/EX source fields.
- bubble_ex  out  1  load a NOP into ID/EX at the next edge.
- flush_id  out  1  squash the IF/ID content at the next edge.
- fwd_sel_rs1 / fwd_sel_rs2  out  2  00 regfile, 01 MEM-stage result, 10 WB-stage result, 11 unused.
- hz_state  out  2  FSM state: 0 RUN, 1 LD_STALL, 2 MD_BUSY, 3 FLUSH.
- stall_count  out  CNT_W  number of cycles with stall_if=1, saturating.

Behaviour:
- Reset (async, rst_n=0): state RUN; all shadow registers (ex_rd, ex_wen, ex_ld, ex_md, mem_rd, mem_wen) cleared; fwd_sel_rs1/rs2 = 00; stall_count = 0; all control outputs = 0. Deasserting reset mid-operation restarts cleanly from RUN.
- A source "matches" a stage when: the address is nonzero AND its used bit is 1 AND the stage wen is 1 AND the addresses are equal. x0 never matches.
- load_use = id_valid AND ex_ld AND (rs1 matches EX OR rs2 matches EX).
- stall_if, stall_id, bubble_ex and flush_id are combinational from the current state, the shadow registers and the ID inputs.
- Priority, highest first: flush > mul/div > load-use.
- RUN:
  - ex_branch_taken=1: flush_id=1 and bubble_ex=1; go to FLUSH.
  - else MD_EN=1 and ex_md=1 and md_done=0: stall_if=1, stall_id=1; go to MD_BUSY.
  - else load_use=1: stall_if=1, stall_id=1, bubble_ex=1; go to LD_STALL.
  - else: no control output asserted.
- LD_STALL: lasts exactly one cycle, then evaluated as RUN. The load is now in MEM, so the dependant is forwarded from WB (10).
- MD_BUSY:
  - While md_done=0: stall_if=1 and stall_id=1, EX is frozen, and a bubble is shifted into MEM.
  - On md_done=1: stalls drop and the state returns to RUN at the next edge.
  - ex_branch_taken is ignored in this state.
- FLUSH: one cycle with no control outputs asserted, then return to RUN.
- Shadow update at each edge:
  - If EX is frozen (MD_BUSY, or RUN entering MD_BUSY): mem_wen<=0 and the EX shadow holds.
  - Otherwise: mem_* <= ex_*, and ex_* <= ID fields. The ID fields are zeroed if bubble_ex=1 or id_valid=0.
- Forward selects, per source, registered when the ID instruction advances (not stalled, not bubbled):
  - 01 if it matches ex_rd; else 10 if it matches mem_rd; else 00.
  - The EX match has priority.
  - fwd_sel holds its value while EX is frozen.
- stall_count increments on every cycle with stall_if=1 and saturates at all-ones.
- Latency: stall/flush are visible in the same cycle as the hazard; fwd_sel is valid in the cycle the consumer sits in EX.

Test Plan:
- add x5 followed by add x6,x5,x7 -> no stall; in the cycle the consumer is in EX, fwd_sel_rs1=01 and fwd_sel_rs2=00.
- lw x5 followed by add x6,x5,x5 -> exactly one cycle of stall_if=stall_id=bubble_ex=1 with hz_state=1; then fwd_sel_rs1=fwd_sel_rs2=10; stall_count=1.
- add x5; nop; sub x8,x5,x0 -> fwd_sel_rs1=10 and fwd_sel_rs2=00. Writer to x0 followed by a reader of x0 -> fwd_sel=00 and no stall.
- mul in EX with md_done arriving 4 cycles later -> stall_if high for 4 cycles and hz_state=2 throughout; release on the md_done cycle; stall_count=4; fwd selects of the waiting instruction unchanged.
- ex_branch_taken=1 coinciding with a load-use in ID -> flush_id=1, bubble_ex=1, stall_if=0; hz_state goes 3 then 0.
- rst_n pulsed low during MD_BUSY -> all outputs 0, hz_state=0, stall_count=0 immediately, without waiting for a clock edge.
